axi_delay_multi: RTL

Multi-channel AXI handshake delay injector for prefetcher stress testing. Sits between an AXI master and slave on up to NUM_CH independent channels (e.g. AW, W, B, AR, R). For each channel it masks valid/ready for a programmable or pseudo-random number of cycles after valid is first seen, then passes the handshake through. Payload wires bypass this block; it gates only valid and ready.

---
 rtl/axi_delay_multi.sv | 127 ++++++++++++
 1 files changed

// File: rtl/axi_delay_multi.sv
// Multi-channel valid/ready delay injector: each channel holds off its handshake for a
// fixed or pseudo-random number of cycles after valid is seen, then passes it through.
module axi_delay_multi #(
   parameter int          NUM_CH          = 5,
   parameter int          DELAY_WIDTH     = 4,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int          STALL_CNT_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    mode,
   input  logic [NUM_CH*DELAY_WIDTH-1:0] cfg_delay,
   input  logic [NUM_CH-1:0]             in_valid,
   input  logic [NUM_CH-1:0]             in_ready,
   output logic [NUM_CH-1:0]             out_valid,
   output logic [NUM_CH-1:0]             out_ready,
   output logic [NUM_CH-1:0]             ch_active,
   output logic [STALL_CNT_WIDTH-1:0]    stall_cnt,
   input  logic                          stall_clr
);

   // state     | meaning
   // S_IDLE    | waiting for in_valid; samples it and loads the delay
   // S_COUNT   | counting the loaded delay down to 1
   // S_ACTIVE  | handshake passed through until a transfer completes
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COUNT  = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   logic              delay_mode;
   logic              rand_mode;
   logic [NUM_CH-1:0] active_vec;
   logic              stall_any;

   assign delay_mode = (mode == 2'd1) || (mode == 2'd2);
   assign rand_mode  = (mode == 2'd2);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [15:0] SEED_RAW = LFSR_SEED ^ 16'(i + 1);
      localparam logic [15:0] SEED     = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

      state_t                 state;
      logic [DELAY_WIDTH-1:0] cnt;
      logic [15:0]            lfsr;
      logic [15:0]            lfsr_next;
      logic                   active_q;
      logic [DELAY_WIDTH-1:0] cfg_slice;
      logic [DELAY_WIDTH-1:0] load_val;

      // Galois form of x^16+x^14+x^13+x^11+1
      assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      assign cfg_slice = cfg_delay[i*DELAY_WIDTH +: DELAY_WIDTH];
      // In random mode the configured value masks the LFSR bits, bounding the delay.
      assign load_val  = rand_mode ? (lfsr[DELAY_WIDTH-1:0] & cfg_slice) : cfg_slice;

      always_ff @(posedge clk) begin
         if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lfsr     <= SEED;
            active_q <= 1'b0;
         end else begin
            if (rand_mode) begin
               lfsr <= lfsr_next;
            end
            if (!delay_mode) begin
               state    <= S_IDLE;
               cnt      <= '0;
               active_q <= 1'b0;
            end else begin
               case (state)
                  S_IDLE: begin
                     if (in_valid[i]) begin
                        if (load_val == '0) begin
                           state    <= S_ACTIVE;
                           active_q <= 1'b1;
                        end else begin
                           state <= S_COUNT;
                           cnt   <= load_val;
                        end
                     end
                  end
                  S_COUNT: begin
                     cnt <= cnt - 1'b1;
                     if (cnt <= 1) begin
                        state    <= S_ACTIVE;
                        active_q <= 1'b1;
                     end
                  end
                  S_ACTIVE: begin
                     if (in_valid[i] && in_ready[i]) begin
                        state    <= S_IDLE;
                        active_q <= 1'b0;
                     end
                  end
                  default: begin
                     state    <= S_IDLE;
                     cnt      <= '0;
                     active_q <= 1'b0;
                  end
               endcase
            end
         end
      end

      assign active_vec[i] = active_q;
   end

   assign out_valid = delay_mode ? (in_valid & active_vec & {NUM_CH{~rst}}) : in_valid;
   assign out_ready = delay_mode ? (in_ready & active_vec & {NUM_CH{~rst}}) : in_ready;
   assign ch_active = active_vec & {NUM_CH{~rst}};

   assign stall_any = delay_mode && |(in_valid & ~active_vec);

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (stall_any && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
